// File: rtl/pb_group_debouncer.sv
// Push-button conditioner: 2-FF synchroniser, per-channel debounce, press/release
// pulses and a per-group "LEDs off" control that is either toggled or momentary.
module pb_group_debouncer #(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit TOGGLE_MODE     = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic             group_clr,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] group_off
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic [N_BTN-1:0] sync1_r;
    logic [N_BTN-1:0] sync2_r;
    logic [N_BTN-1:0] level_r;
    logic [N_BTN-1:0] press_r;
    logic [N_BTN-1:0] release_r;
    logic [CNT_W-1:0] cnt_r      [N_BTN];
    logic [CNT_W-1:0] cnt_next_s [N_BTN];
    logic [N_BTN-1:0] accept_s;

    // Two-stage synchroniser; the only logic that sees btn_raw.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= {N_BTN{1'b0}};
            sync2_r <= {N_BTN{1'b0}};
        end else begin
            sync1_r <= btn_raw;
            sync2_r <= sync1_r;
        end
    end

    // A matching sample restarts the count, so a single bounce sample rejects the edge.
    always_comb begin
        accept_s = {N_BTN{1'b0}};
        for (int k = 0; k < N_BTN; k++) begin
            cnt_next_s[k] = cnt_r[k];
            if (sync2_r[k] == level_r[k]) begin
                cnt_next_s[k] = CNT_ZERO;
            end else if (cnt_r[k] == CNT_LAST) begin
                accept_s[k]   = 1'b1;
                cnt_next_s[k] = CNT_ZERO;
            end else begin
                cnt_next_s[k] = cnt_r[k] + CNT_ONE;
            end
        end
    end

    // Per-channel stability counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_BTN; k++) begin
                cnt_r[k] <= CNT_ZERO;
            end
        end else begin
            for (int k = 0; k < N_BTN; k++) begin
                cnt_r[k] <= cnt_next_s[k];
            end
        end
    end

    // Accepted level plus edge pulses registered in the same cycle the level changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_r   <= {N_BTN{1'b0}};
            press_r   <= {N_BTN{1'b0}};
            release_r <= {N_BTN{1'b0}};
        end else begin
            level_r   <= level_r ^ accept_s;
            press_r   <= accept_s & sync2_r;
            release_r <= accept_s & ~sync2_r;
        end
    end

    assign btn_level   = level_r;
    assign btn_press   = press_r;
    assign btn_release = release_r;

    generate
        if (TOGGLE_MODE) begin : g_toggle
            logic [N_BTN-1:0] goff_r;

            // Each press flips its group; a clear in the same cycle takes priority.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    goff_r <= {N_BTN{1'b0}};
                end else if (group_clr) begin
                    goff_r <= {N_BTN{1'b0}};
                end else begin
                    goff_r <= goff_r ^ press_r;
                end
            end

            assign group_off = goff_r;
        end else begin : g_momentary
            logic unused_clr;
            assign unused_clr = group_clr;
            assign group_off  = level_r;
        end
    endgenerate

endmodule

// File: tb/tb_pb_group_debouncer.sv
// Randomised and directed bench for pb_group_debouncer (DEBOUNCE_CYCLES=4), one
// toggle-mode and one momentary-mode instance, checked against a streak-count model.
module tb_pb_group_debouncer;

    localparam int D = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] btn_raw;
    logic       group_clr;
    logic [3:0] t_level, t_press, t_release, t_goff;
    logic [3:0] m_level_o, m_press_o, m_release_o, m_goff_o;

    int vectors;
    int errors;

    // Reference model state
    logic [3:0] raw_q[$];
    logic [3:0] m_lvl, m_press, m_rel, m_goff;
    int         streak[4];

    pb_group_debouncer #(.N_BTN(4), .DEBOUNCE_CYCLES(D), .TOGGLE_MODE(1'b1)) dut_t (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .group_clr(group_clr),
        .btn_level(t_level), .btn_press(t_press), .btn_release(t_release), .group_off(t_goff)
    );

    pb_group_debouncer #(.N_BTN(4), .DEBOUNCE_CYCLES(D), .TOGGLE_MODE(1'b0)) dut_m (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .group_clr(group_clr),
        .btn_level(m_level_o), .btn_press(m_press_o), .btn_release(m_release_o), .group_off(m_goff_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        raw_q.delete();
        m_lvl = 4'b0; m_press = 4'b0; m_rel = 4'b0; m_goff = 4'b0;
        for (int k = 0; k < 4; k++) streak[k] = 0;
    endtask

    // Level changes once D consecutive synchronised samples disagree with it;
    // the synchronised sample at an edge is the raw value sampled two edges earlier.
    task automatic model_edge(input logic [3:0] raw, input logic clr);
        logic [3:0] s;
        logic [3:0] nxt_goff;
        raw_q.push_back(raw);
        if (raw_q.size() > 3) void'(raw_q.pop_front());
        s = (raw_q.size() == 3) ? raw_q[0] : 4'b0;
        nxt_goff = clr ? 4'b0 : (m_goff ^ m_press);
        m_press = 4'b0;
        m_rel   = 4'b0;
        for (int k = 0; k < 4; k++) begin
            if (s[k] != m_lvl[k]) begin
                streak[k]++;
                if (streak[k] == D) begin
                    m_lvl[k] = s[k];
                    if (s[k]) m_press[k] = 1'b1;
                    else      m_rel[k]   = 1'b1;
                    streak[k] = 0;
                end
            end else begin
                streak[k] = 0;
            end
        end
        m_goff = nxt_goff;
    endtask

    task automatic check_all();
        check_val("t_level",   {28'b0, t_level},     {28'b0, m_lvl});
        check_val("t_press",   {28'b0, t_press},     {28'b0, m_press});
        check_val("t_release", {28'b0, t_release},   {28'b0, m_rel});
        check_val("t_goff",    {28'b0, t_goff},      {28'b0, m_goff});
        check_val("m_level",   {28'b0, m_level_o},   {28'b0, m_lvl});
        check_val("m_press",   {28'b0, m_press_o},   {28'b0, m_press});
        check_val("m_release", {28'b0, m_release_o}, {28'b0, m_rel});
        check_val("m_goff",    {28'b0, m_goff_o},    {28'b0, m_lvl});
    endtask

    task automatic tick(input logic [3:0] raw, input logic clr);
        btn_raw   = raw;
        group_clr = clr;
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_edge(raw, clr);
        #1;
        check_all();
    endtask

    task automatic hold(input logic [3:0] raw, input int n);
        for (int i = 0; i < n; i++) tick(raw, 1'b0);
    endtask

    // Counts edges until press[ch] on the toggle instance, bounded to 20.
    task automatic press_latency(input logic [3:0] raw, input int ch, input string tag);
        int n;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            tick(raw, 1'b0);
            if (t_press[ch] && n == 0) n = i;
            if (n != 0) break;
        end
        check_val(tag, n, D + 2);
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        rst_n = 1'b0; btn_raw = 4'b0; group_clr = 1'b0;
        model_reset();
        #3;
        check_all();
        tick(4'b0, 1'b0);
        #2 rst_n = 1'b1;
        hold(4'b0000, 3);

        // Single held press, then no further toggles while held
        press_latency(4'b0001, 0, "lat_btn0");
        hold(4'b0001, 8);
        check_val("goff_after_hold", {28'b0, t_goff}, 32'h1);

        // Bounce on button 1
        tick(4'b0011, 1'b0); tick(4'b0001, 1'b0);
        tick(4'b0011, 1'b0); tick(4'b0001, 1'b0);
        press_latency(4'b0011, 1, "lat_bounce");
        hold(4'b0011, 4);

        // Press / release / press on button 2
        hold(4'b0111, 8);
        check_val("goff2_first", {31'b0, t_goff[2]}, 32'h1);
        hold(4'b0011, 8);
        hold(4'b0111, 8);
        check_val("goff2_second", {31'b0, t_goff[2]}, 32'h0);
        hold(4'b0011, 8);
        check_val("goff_pre_clr", {28'b0, t_goff}, 32'h3);

        // Clear coincident with press on button 3
        hold(4'b1011, D + 2);
        check_val("press3_seen", {31'b0, t_press[3]}, 32'h1);
        tick(4'b1011, 1'b1);
        check_val("goff_cleared", {28'b0, t_goff}, 32'h0);
        hold(4'b1011, 4);

        // Async reset mid-count with group_off = 1010
        hold(4'b0000, 8);
        hold(4'b1010, 8);
        hold(4'b0000, 8);
        check_val("goff_pre_rst", {28'b0, t_goff}, 32'ha);
        hold(4'b0001, 4);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        tick(4'b0001, 1'b0);
        #2 rst_n = 1'b1;
        press_latency(4'b0001, 0, "lat_after_rst");
        hold(4'b0001, 4);

        // Momentary instance: all held then released, clear pulses ignored
        tick(4'b1111, 1'b1);
        hold(4'b1111, 8);
        check_val("mom_all_on", {28'b0, m_goff_o}, 32'hf);
        tick(4'b0000, 1'b1);
        hold(4'b0000, 8);
        check_val("mom_all_off", {28'b0, m_goff_o}, 32'h0);

        // Randomised bouncing/stable traffic with sporadic clears
        begin
            logic [3:0] r;
            r = 4'b0;
            for (int i = 0; i < 600; i++) begin
                for (int k = 0; k < 4; k++) begin
                    if ($urandom_range(0, 5) == 0) r[k] = ~r[k];
                end
                tick(r, ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
